// File: rtl/data_loop_pkg.sv
// Shared types and constants for the LED data-loop sequencer.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package data_loop_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2,
    ERROR  = 2'd3
  } state_t;

  localparam logic [3:0] CMD_INIT  = 4'h0;
  localparam logic [7:0] BCAST_ID  = 8'hFF;
  localparam int         DATA_W    = 48;
  localparam int         NUM_SLOTS = 4;

  typedef logic [DATA_W-1:0] beat_t;

endpackage

// File: rtl/beat_timeout_counter.sv
// Idle-cycle counter between data beats; raises hit when the count equals TIMEOUT_CYC.
// Latency: hit is registered-count based, valid the cycle after the count reaches the limit.
// Backpressure: none; saturates at the limit until cleared.
// Ports: clk, rst (sync active-high), clr (zero count), en (count one cycle), hit (terminal flag).
module beat_timeout_counter #(
  parameter int unsigned TIMEOUT_CYC = 1023
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic hit
);

  localparam logic [31:0] TERM_FULL = TIMEOUT_CYC;
  localparam logic [15:0] TERM      = TERM_FULL[15:0];

  logic [15:0] cnt_q;

  assign hit = (cnt_q == TERM);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 16'd0;
    end else if (clr) begin
      cnt_q <= 16'd0;
    end else if (en && !hit) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

endmodule

// File: rtl/data_loop_sequencer.sv
// Front end for the LED datapath: filters addressed commands, streams a 4-beat burst, commits it as a frame.
// Latency: beat -> DATA_i in 1 cycle; last beat -> CTS and DATA_loop_n in 2 cycles; init pulse 1 cycle after command.
// Backpressure: cmd_ready only in IDLE/ERROR, in_ready only in LOAD; an idle gap of TIMEOUT_CYC cycles aborts to ERROR.
// Ports: sys_clk/sys_resetb (sync, active-high); cmd_valid/cmd_ready/cmd_i/operand_id_i command channel;
//   in_valid/in_ready/in_data beat channel; CMD/Operand_ID/DATA_i/loop_count slot-write outputs;
//   init/CTS pulses; error_flag sticky; DATA_loop_0..3 committed frame; busy = not IDLE.
module data_loop_sequencer
  import data_loop_pkg::*;
#(
  parameter logic [4:0]  ROW         = 5'b0,
  parameter logic [2:0]  COLUMN      = 3'b0,
  parameter int unsigned TIMEOUT_CYC = 1023
) (
  input  logic              sys_clk,
  input  logic              sys_resetb,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_i,
  input  logic [7:0]        operand_id_i,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic [3:0]        CMD,
  output logic [7:0]        Operand_ID,
  output logic [DATA_W-1:0] DATA_i,
  output logic [1:0]        loop_count,
  output logic              init,
  output logic              CTS,
  output logic              error_flag,
  output logic [DATA_W-1:0] DATA_loop_0,
  output logic [DATA_W-1:0] DATA_loop_1,
  output logic [DATA_W-1:0] DATA_loop_2,
  output logic [DATA_W-1:0] DATA_loop_3,
  output logic              busy
);

  state_t      state_q, state_d;
  logic [1:0]  beat_idx_q;
  beat_t       shadow_q    [NUM_SLOTS];
  beat_t       data_loop_q [NUM_SLOTS];

  logic addr_match, is_init, cmd_acc, beat_acc, start_frame;
  logic timeout_hit, to_clr, to_en;

  assign addr_match  = (operand_id_i == {ROW, COLUMN}) || (operand_id_i == BCAST_ID);
  assign is_init     = (cmd_i == CMD_INIT);
  assign cmd_acc     = cmd_valid && cmd_ready;
  assign beat_acc    = in_valid && in_ready;
  assign start_frame = cmd_acc && addr_match && !is_init;

  assign to_clr = beat_acc || start_frame;
  assign to_en  = (state_q == LOAD) && !beat_acc;

  beat_timeout_counter #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout (
    .clk (sys_clk),
    .rst (sys_resetb),
    .clr (to_clr),
    .en  (to_en),
    .hit (timeout_hit)
  );

  assign busy        = (state_q != IDLE);
  assign DATA_loop_0 = data_loop_q[0];
  assign DATA_loop_1 = data_loop_q[1];
  assign DATA_loop_2 = data_loop_q[2];
  assign DATA_loop_3 = data_loop_q[3];

  always_ff @(posedge sys_clk) begin
    if (sys_resetb) state_q <= IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    in_ready  = 1'b0;
    case (state_q)
      IDLE, ERROR: begin
        cmd_ready = 1'b1;
        // ERROR behaves like IDLE once a command arrives, even an unmatched one.
        if (cmd_valid) state_d = (addr_match && !is_init) ? LOAD : IDLE;
      end
      LOAD: begin
        // No beat is taken on the expiry cycle so an abort never half-writes a slot.
        in_ready = !timeout_hit;
        if (timeout_hit)                          state_d = ERROR;
        else if (in_valid && beat_idx_q == 2'd3)  state_d = COMMIT;
      end
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Keep both handshakes low while reset is held so nothing is consumed.
    if (sys_resetb) begin
      cmd_ready = 1'b0;
      in_ready  = 1'b0;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_resetb) begin
      CMD        <= 4'h0;
      Operand_ID <= 8'h00;
      DATA_i     <= '0;
      loop_count <= 2'd0;
      init       <= 1'b0;
      CTS        <= 1'b0;
      error_flag <= 1'b0;
      beat_idx_q <= 2'd0;
      for (int n = 0; n < NUM_SLOTS; n++) begin
        shadow_q[n]    <= '0;
        data_loop_q[n] <= '0;
      end
    end else begin
      init <= 1'b0;
      CTS  <= 1'b0;

      if (cmd_acc) begin
        error_flag <= 1'b0;
        if (addr_match && is_init) begin
          init <= 1'b1;
          for (int n = 0; n < NUM_SLOTS; n++) data_loop_q[n] <= '0;
        end else if (addr_match) begin
          CMD        <= cmd_i;
          Operand_ID <= operand_id_i;
          beat_idx_q <= 2'd0;
        end
      end

      if (beat_acc) begin
        DATA_i               <= in_data;
        loop_count           <= beat_idx_q;
        shadow_q[beat_idx_q] <= in_data;
        beat_idx_q           <= beat_idx_q + 2'd1;
      end

      if (state_q == COMMIT) begin
        CTS <= 1'b1;
        for (int n = 0; n < NUM_SLOTS; n++) data_loop_q[n] <= shadow_q[n];
      end

      if (state_q == LOAD && timeout_hit) error_flag <= 1'b1;
    end
  end

endmodule

// File: tb/tb_data_loop_sequencer.sv
// Directed bench for data_loop_sequencer (ROW=2, COLUMN=5, TIMEOUT_CYC=8).
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: handshakes driven directly; no stalls beyond the timeout scenario.
module tb_data_loop_sequencer;

  logic        sys_clk = 1'b0;
  logic        sys_resetb;
  logic        cmd_valid, cmd_ready;
  logic [3:0]  cmd_i;
  logic [7:0]  operand_id_i;
  logic        in_valid, in_ready;
  logic [47:0] in_data;
  logic [3:0]  CMD;
  logic [7:0]  Operand_ID;
  logic [47:0] DATA_i;
  logic [1:0]  loop_count;
  logic        init, CTS, error_flag, busy;
  logic [47:0] DATA_loop_0, DATA_loop_1, DATA_loop_2, DATA_loop_3;

  int n_vec = 0;
  int n_bad = 0;

  data_loop_sequencer #(
    .ROW (5'd2), .COLUMN (3'd5), .TIMEOUT_CYC (8)
  ) dut (
    .sys_clk (sys_clk), .sys_resetb (sys_resetb),
    .cmd_valid (cmd_valid), .cmd_ready (cmd_ready), .cmd_i (cmd_i), .operand_id_i (operand_id_i),
    .in_valid (in_valid), .in_ready (in_ready), .in_data (in_data),
    .CMD (CMD), .Operand_ID (Operand_ID), .DATA_i (DATA_i), .loop_count (loop_count),
    .init (init), .CTS (CTS), .error_flag (error_flag),
    .DATA_loop_0 (DATA_loop_0), .DATA_loop_1 (DATA_loop_1),
    .DATA_loop_2 (DATA_loop_2), .DATA_loop_3 (DATA_loop_3),
    .busy (busy)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic send_cmd(input logic [3:0] c, input logic [7:0] id);
    cmd_valid = 1'b1; cmd_i = c; operand_id_i = id;
    tick();
    cmd_valid = 1'b0;
  endtask

  // Four back-to-back beats from base, then the COMMIT and CTS cycles.
  task automatic run_beats(input logic [47:0] base);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = base + 48'(i);
      tick();
      n_vec++; if (DATA_i !== base + 48'(i)) begin n_bad++; $display("FAIL beat_data[%0d]: got %h want %h", i, DATA_i, base + 48'(i)); end
      n_vec++; if (loop_count !== 2'(i)) begin n_bad++; $display("FAIL beat_idx[%0d]: got %0d want %0d", i, loop_count, i); end
      n_vec++; if (CTS !== 1'b0) begin n_bad++; $display("FAIL early_cts[%0d]: got %b want 0", i, CTS); end
    end
    in_valid = 1'b0;
    n_vec++; if ({busy, in_ready} !== 2'b10) begin n_bad++; $display("FAIL commit_state: busy,in_ready got %b want 10", {busy, in_ready}); end
    tick();
    n_vec++; if (CTS !== 1'b1) begin n_bad++; $display("FAIL cts_pulse: got %b want 1", CTS); end
    n_vec++; if ({DATA_loop_0, DATA_loop_1, DATA_loop_2, DATA_loop_3} !== {base, base + 48'd1, base + 48'd2, base + 48'd3}) begin
      n_bad++; $display("FAIL frame_commit: got %h %h %h %h want base %h", DATA_loop_0, DATA_loop_1, DATA_loop_2, DATA_loop_3, base); end
    n_vec++; if ({busy, cmd_ready} !== 2'b01) begin n_bad++; $display("FAIL post_commit: busy,cmd_ready got %b want 01", {busy, cmd_ready}); end
    tick();
    n_vec++; if (CTS !== 1'b0) begin n_bad++; $display("FAIL cts_width: got %b want 0", CTS); end
  endtask

  task automatic test_reset();
    sys_resetb = 1'b1; in_valid = 1'b1; in_data = 48'hDEAD;
    cmd_valid = 1'b0; cmd_i = 4'h0; operand_id_i = 8'h00;
    repeat (3) tick();
    n_vec++; if ({busy, cmd_ready, in_ready, init, CTS, error_flag} !== 6'b0) begin
      n_bad++; $display("FAIL reset_ctrl: got %b want 000000", {busy, cmd_ready, in_ready, init, CTS, error_flag}); end
    n_vec++; if ({CMD, Operand_ID, loop_count, DATA_i} !== 62'b0) begin
      n_bad++; $display("FAIL reset_slot: CMD %h ID %h lc %0d DATA_i %h want all 0", CMD, Operand_ID, loop_count, DATA_i); end
    n_vec++; if ({DATA_loop_0, DATA_loop_1, DATA_loop_2, DATA_loop_3} !== 192'b0) begin
      n_bad++; $display("FAIL reset_loops: got %h %h %h %h want 0", DATA_loop_0, DATA_loop_1, DATA_loop_2, DATA_loop_3); end
    sys_resetb = 1'b0; in_valid = 1'b0;
    tick();
    n_vec++; if ({busy, cmd_ready, in_ready} !== 3'b010) begin
      n_bad++; $display("FAIL reset_release: busy,cmd_ready,in_ready got %b want 010", {busy, cmd_ready, in_ready}); end
  endtask

  task automatic test_normal_frame();
    send_cmd(4'h3, 8'h15);
    n_vec++; if ({busy, cmd_ready, in_ready} !== 3'b101) begin
      n_bad++; $display("FAIL load_entry: busy,cmd_ready,in_ready got %b want 101", {busy, cmd_ready, in_ready}); end
    n_vec++; if ({CMD, Operand_ID} !== {4'h3, 8'h15}) begin
      n_bad++; $display("FAIL cmd_latch: got %h/%h want 3/15", CMD, Operand_ID); end
    run_beats(48'hA0);
  endtask

  task automatic test_addr_filter();
    send_cmd(4'h7, 8'h16);
    n_vec++; if ({busy, cmd_ready} !== 2'b01) begin n_bad++; $display("FAIL addr_drop: busy,cmd_ready got %b want 01", {busy, cmd_ready}); end
    n_vec++; if (CMD !== 4'h3) begin n_bad++; $display("FAIL addr_drop_cmd: got %h want 3", CMD); end
    send_cmd(4'h1, 8'hFF);
    n_vec++; if ({busy, in_ready} !== 2'b11) begin n_bad++; $display("FAIL bcast_load: busy,in_ready got %b want 11", {busy, in_ready}); end
    n_vec++; if ({CMD, Operand_ID} !== {4'h1, 8'hFF}) begin n_bad++; $display("FAIL bcast_latch: got %h/%h want 1/ff", CMD, Operand_ID); end
  endtask

  // Continues the broadcast frame opened by test_addr_filter.
  task automatic test_timeout();
    logic seen_cts;
    logic early_err;
    logic risen;
    seen_cts = 1'b0; early_err = 1'b0; risen = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = 48'hC0 + 48'(i);
      tick();
    end
    in_valid = 1'b0;
    n_vec++; if ({DATA_i, loop_count} !== {48'hC1, 2'd1}) begin n_bad++; $display("FAIL to_beats: got %h/%0d want c1/1", DATA_i, loop_count); end
    for (int k = 0; k < 7; k++) begin
      tick();
      if (CTS) seen_cts = 1'b1;
      if (error_flag) early_err = 1'b1;
    end
    n_vec++; if (early_err !== 1'b0) begin n_bad++; $display("FAIL to_early: error_flag got 1 want 0 within 7 idle cycles"); end
    for (int k = 0; k < 4 && !risen; k++) begin
      tick();
      if (CTS) seen_cts = 1'b1;
      risen = error_flag;
    end
    n_vec++; if (risen !== 1'b1) begin n_bad++; $display("FAIL to_error: error_flag got 0 want 1 within budget"); end
    n_vec++; if (seen_cts !== 1'b0) begin n_bad++; $display("FAIL to_cts: CTS seen got 1 want 0"); end
    n_vec++; if ({DATA_loop_0, DATA_loop_1, DATA_loop_2, DATA_loop_3} !== {48'hA0, 48'hA1, 48'hA2, 48'hA3}) begin
      n_bad++; $display("FAIL to_loops: got %h %h %h %h want a0..a3", DATA_loop_0, DATA_loop_1, DATA_loop_2, DATA_loop_3); end
    n_vec++; if ({busy, cmd_ready, in_ready} !== 3'b110) begin
      n_bad++; $display("FAIL err_state: busy,cmd_ready,in_ready got %b want 110", {busy, cmd_ready, in_ready}); end
    in_valid = 1'b1; in_data = 48'hEE;
    tick();
    in_valid = 1'b0;
    n_vec++; if ({DATA_i, loop_count, error_flag} !== {48'hC1, 2'd1, 1'b1}) begin
      n_bad++; $display("FAIL err_ignore: got %h/%0d/%b want c1/1/1", DATA_i, loop_count, error_flag); end
  endtask

  task automatic test_error_clear();
    send_cmd(4'h3, 8'h15);
    n_vec++; if ({error_flag, busy, in_ready} !== 3'b011) begin
      n_bad++; $display("FAIL err_clear: error_flag,busy,in_ready got %b want 011", {error_flag, busy, in_ready}); end
    run_beats(48'hD0);
  endtask

  task automatic test_init();
    send_cmd(4'h0, 8'h15);
    n_vec++; if ({init, CTS, busy} !== 3'b100) begin n_bad++; $display("FAIL init_pulse: init,CTS,busy got %b want 100", {init, CTS, busy}); end
    n_vec++; if ({DATA_loop_0, DATA_loop_1, DATA_loop_2, DATA_loop_3} !== 192'b0) begin
      n_bad++; $display("FAIL init_clear: got %h %h %h %h want 0", DATA_loop_0, DATA_loop_1, DATA_loop_2, DATA_loop_3); end
    tick();
    n_vec++; if ({init, CTS} !== 2'b00) begin n_bad++; $display("FAIL init_width: init,CTS got %b want 00", {init, CTS}); end
  endtask

  task automatic test_reset_mid_frame();
    logic seen_cts;
    seen_cts = 1'b0;
    send_cmd(4'h2, 8'hFF);
    run_beats(48'hE0);
    send_cmd(4'h3, 8'h15);
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = 48'hB0 + 48'(i);
      tick();
    end
    in_valid = 1'b0;
    sys_resetb = 1'b1;
    tick();
    sys_resetb = 1'b0;
    n_vec++; if ({busy, CTS, loop_count, DATA_i} !== 52'b0) begin
      n_bad++; $display("FAIL midrst_state: busy %b CTS %b lc %0d DATA_i %h want 0", busy, CTS, loop_count, DATA_i); end
    n_vec++; if ({DATA_loop_0, DATA_loop_1, DATA_loop_2, DATA_loop_3} !== 192'b0) begin
      n_bad++; $display("FAIL midrst_loops: got %h %h %h %h want 0", DATA_loop_0, DATA_loop_1, DATA_loop_2, DATA_loop_3); end
    repeat (3) begin
      tick();
      if (CTS) seen_cts = 1'b1;
    end
    n_vec++; if (seen_cts !== 1'b0) begin n_bad++; $display("FAIL midrst_cts: CTS seen got 1 want 0"); end
    send_cmd(4'h3, 8'h15);
    run_beats(48'hF0);
  endtask

  task automatic test_back_to_back();
    send_cmd(4'h4, 8'h15);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 48'h40 + 48'(i);
      tick();
    end
    in_valid = 1'b0;
    cmd_valid = 1'b1; cmd_i = 4'h5; operand_id_i = 8'h15;
    tick();
    n_vec++; if ({CTS, cmd_ready} !== 2'b11) begin n_bad++; $display("FAIL b2b_cts: CTS,cmd_ready got %b want 11", {CTS, cmd_ready}); end
    n_vec++; if (DATA_loop_3 !== 48'h43) begin n_bad++; $display("FAIL b2b_loop3: got %h want 43", DATA_loop_3); end
    tick();
    cmd_valid = 1'b0;
    n_vec++; if ({CMD, busy, in_ready, CTS} !== {4'h5, 3'b110}) begin
      n_bad++; $display("FAIL b2b_accept: CMD %h busy %b in_ready %b CTS %b want 5/1/1/0", CMD, busy, in_ready, CTS); end
    run_beats(48'h50);
  endtask

  initial begin
    test_reset();
    test_normal_frame();
    test_addr_filter();
    test_timeout();
    test_error_clear();
    test_init();
    test_reset_mid_frame();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/data_loop_sequencer.md
Name: data_loop_sequencer

Overview:
- Front-end controller for the LED data-process datapath. Accepts an addressed command followed by a 4-beat 48-bit data burst.
- Drives the datapath's DATA_i/loop_count slot-write interface one beat at a time, then commits the frame to the loop registers and pulses CTS to the decoder.
- Owns command address filtering (ROW/COLUMN match), the init command, inter-beat timeout and error_flag generation.

Parameters:
- ROW, 5'b0, row address of this tile; forms Operand_ID[7:3].
- COLUMN, 3'b0, column address of this tile; forms Operand_ID[2:0].
- TIMEOUT_CYC, 1023, maximum idle cycles allowed between data beats before abort (range 1..65535).

Ports:
- sys_clk  in  1  system clock; all logic rises on posedge.
- sys_resetb  in  1  reset; synchronous, active-high despite the name.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid and cmd_ready are both high.
- cmd_i  in  4  command code.
- operand_id_i  in  8  target address {row[4:0], col[2:0]}; 8'hFF is broadcast.
- in_valid  in  1  data beat present.
- in_ready  out  1  data beat accepted when in_valid and in_ready are both high.
- in_data  in  48  data beat.
- CMD  out  4  latched command, to the datapath.
- Operand_ID  out  8  latched operand, to the datapath.
- DATA_i  out  48  registered beat data, to the datapath.
- loop_count  out  2  slot index of DATA_i.
- init  out  1  one-cycle init pulse.
- CTS  out  1  one-cycle frame-commit pulse.
- error_flag  out  1  sticky error.
- DATA_loop_0..DATA_loop_3  out  48 each  last committed frame.
- busy  out  1  high whenever the FSM state is not IDLE.

Behaviour:
- Reset: all outputs are 0. FSM goes to IDLE, beat counter to 0, timeout counter to 0, and all DATA_loop_n to 48'h0. Reset in any state aborts with no CTS.
- Address match: operand_id_i == {ROW,COLUMN} or operand_id_i == 8'hFF.
- FSM states: IDLE, LOAD, COMMIT, ERROR.
- IDLE: cmd_ready=1, in_ready=0.
  - Accepted command with no address match: dropped; stay in IDLE.
  - Match and cmd_i == 4'h0 (INIT): init=1 on the next cycle for 1 cycle. DATA_loop_n are cleared to 0 on that same cycle. Stay in IDLE.
  - Match and any other code: latch CMD and Operand_ID, clear the beat counter and timeout counter, go to LOAD.
- LOAD: cmd_ready=0, in_ready=1.
  - Beat accepted in cycle t: DATA_i=in_data and loop_count=beat index at t+1. Beat index goes 0,1,2,3.
  - Each beat is also written into a shadow slot[index].
  - Timeout counter resets on each accepted beat and increments on every other LOAD cycle.
  - Beat 3 accepted at t: go to COMMIT at t+1. in_ready=0 from t+1.
  - Timeout counter reaches TIMEOUT_CYC: go to ERROR. Shadow is discarded and DATA_loop_n are unchanged.
- COMMIT (1 cycle, at t+1):
  - At t+2: CTS=1 for 1 cycle, DATA_loop_n <= shadow[n], FSM to IDLE.
  - CTS and the new DATA_loop values are visible on the same cycle.
- ERROR: error_flag=1 (sticky), cmd_ready=1, in_ready=0.
  - Any accepted command clears error_flag on the next cycle and is then processed exactly as in IDLE, same cycle.
- DATA_i and loop_count hold their last values when no beat is accepted; no auto-clear.
- cmd_valid while busy (LOAD/COMMIT) is not accepted (cmd_ready=0); the upstream must hold it.
- in_valid in IDLE/ERROR is ignored (in_ready=0).
- Throughput: back-to-back beats at 1 per cycle. Minimum frame is 1 cmd cycle + 4 beats + 1 COMMIT = 6 cycles. The next command can be accepted on the CTS cycle.

Decomposition:
- Shared package data_loop_pkg:
  - state enum {IDLE, LOAD, COMMIT, ERROR}
  - CMD_INIT = 4'h0
  - BCAST_ID = 8'hFF
  - DATA_W = 48
  - NUM_SLOTS = 4
- Sub-module beat_timeout_counter: 16-bit counter with clear, enable, and terminal flag at TIMEOUT_CYC. Everything else stays in the top.

Test Plan:
- Reset: hold sys_resetb=1 for 3 cycles with in_valid=1 → all outputs 0, busy=0, cmd_ready=1 after release.
- Normal frame (ROW=2, COLUMN=5): cmd_i=4'h3, operand_id_i=8'h15, then beats 48'hA0..A3 back-to-back → loop_count 0,1,2,3 with matching DATA_i each 1 cycle after acceptance; CTS pulses 2 cycles after beat 3; DATA_loop_0..3 = A0..A3.
- Address filtering: operand_id_i=8'h16 → dropped, busy stays 0. Then 8'hFF with cmd 4'h1 → LOAD entered.
- Timeout (TIMEOUT_CYC=8): accept 2 beats then stall → error_flag=1 after 8 idle cycles, no CTS, DATA_loop unchanged. A new valid command clears error_flag.
- Init: cmd_i=4'h0 to a matching ID after a committed frame → init=1 for 1 cycle, DATA_loop_n=0, CTS stays 0.
- Reset mid-frame: reset after beat 1 → no CTS, DATA_loop=0, FSM in IDLE; a following full frame commits correctly.
